// File: rtl/seq_exp_golomb_enc_if.sv
// Exp-Golomb encoder stream interface.
//   in_*  : syntax element request (valid/ready), mode, value, te range flag
//   out_* : codeword response (valid/ready), right-aligned code, length, error
// slave  = encoder side, master = producer/consumer side.
interface seq_exp_golomb_enc_if #(
   parameter int VAL_W  = 16,
   parameter int CODE_W = 2*VAL_W+1
);
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_mode;
   logic [VAL_W-1:0]  in_val;
   logic              in_te_max1;
   logic              out_valid;
   logic              out_ready;
   logic [CODE_W-1:0] out_code;
   logic [5:0]        out_len;
   logic              out_err;

   modport master (
      output in_valid, in_mode, in_val, in_te_max1, out_ready,
      input  in_ready, out_valid, out_code, out_len, out_err
   );

   modport slave (
      input  in_valid, in_mode, in_val, in_te_max1, out_ready,
      output in_ready, out_valid, out_code, out_len, out_err
   );
endinterface

// File: rtl/seq_exp_golomb_enc.sv
// Two-stage Exp-Golomb encoder for H.264 ue/se/me/te syntax elements.
//   clk, rst : clock, synchronous active-high reset
//   bus      : seq_exp_golomb_enc_if.slave (element in, codeword out)
//   mb_start : clears the emitted-bit counter
//   bit_cnt  : saturating count of emitted codeword bits
// Stage 1 maps the element to codeNum, stage 2 builds codeNum+1 and its length.
// Optional feature macro: EG_BITCNT_EN (bit counter); when undefined bit_cnt=0.
module seq_exp_golomb_enc #(
   parameter int VAL_W  = 16,
   parameter int CODE_W = 2*VAL_W+1
) (
   input  logic                 clk,
   input  logic                 rst,
   seq_exp_golomb_enc_if.slave  bus,
   input  logic                 mb_start,
   output logic [15:0]          bit_cnt
);
   localparam int CN_W = VAL_W + 1;

   // coded_block_pattern -> codeNum, inverse of the me mapping table
   // (ChromaArrayType 1/2). Entries past 47 are never used (range error).
   localparam logic [5:0] ME_INTRA [64] = '{
      6'd3,  6'd29, 6'd30, 6'd17, 6'd31, 6'd18, 6'd37, 6'd8,
      6'd32, 6'd38, 6'd19, 6'd9,  6'd20, 6'd10, 6'd11, 6'd2,
      6'd16, 6'd33, 6'd34, 6'd21, 6'd35, 6'd22, 6'd39, 6'd4,
      6'd36, 6'd40, 6'd23, 6'd5,  6'd24, 6'd6,  6'd7,  6'd1,
      6'd41, 6'd42, 6'd43, 6'd25, 6'd44, 6'd26, 6'd46, 6'd12,
      6'd45, 6'd47, 6'd27, 6'd13, 6'd28, 6'd14, 6'd15, 6'd0,
      6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,
      6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0};
   localparam logic [5:0] ME_INTER [64] = '{
      6'd0,  6'd2,  6'd3,  6'd7,  6'd4,  6'd8,  6'd17, 6'd13,
      6'd5,  6'd18, 6'd9,  6'd14, 6'd10, 6'd15, 6'd16, 6'd11,
      6'd1,  6'd32, 6'd33, 6'd36, 6'd34, 6'd37, 6'd44, 6'd40,
      6'd35, 6'd45, 6'd38, 6'd41, 6'd39, 6'd42, 6'd43, 6'd19,
      6'd6,  6'd24, 6'd25, 6'd20, 6'd26, 6'd21, 6'd46, 6'd28,
      6'd27, 6'd47, 6'd22, 6'd29, 6'd23, 6'd30, 6'd31, 6'd12,
      6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,
      6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0};

   logic              s1_valid, s1_err, s1_te1, s1_tebit;
   logic [CN_W-1:0]   s1_cn;
   logic              s2_valid, s2_err;
   logic [CODE_W-1:0] s2_code;
   logic [5:0]        s2_len;

   logic              acc, s2_load, out_hs;
   logic [CN_W-1:0]   cn_d, se_neg, cn1;
   logic              err_d, te1_d, tebit_d, me_bad;
   logic [5:0]        cbp, msb;
   logic [CODE_W-1:0] code_d;
   logic [5:0]        len_d;

   assign bus.in_ready  = !rst && (!s1_valid || !s2_valid || bus.out_ready);
   assign acc           = bus.in_valid && bus.in_ready;
   assign s2_load       = s1_valid && (!s2_valid || bus.out_ready);
   assign out_hs        = s2_valid && bus.out_ready;
   assign bus.out_valid = s2_valid;
   assign bus.out_code  = s2_code;
   assign bus.out_len   = s2_len;
   assign bus.out_err   = s2_err;

   // magnitude of a non-positive se value, one bit wider so -min fits
   assign se_neg = CN_W'(0) - {bus.in_val[VAL_W-1], bus.in_val};
   assign cbp    = bus.in_val[5:0];
   assign me_bad = (|bus.in_val[VAL_W-1:6]) || (cbp > 6'd47);

   // stage 1: element -> codeNum
   always_comb begin
      cn_d    = '0;
      err_d   = 1'b0;
      te1_d   = 1'b0;
      tebit_d = 1'b0;
      case (bus.in_mode)
         3'd0: cn_d = {1'b0, bus.in_val};
         3'd1: begin
            if (!bus.in_val[VAL_W-1] && (|bus.in_val))
               cn_d = {bus.in_val, 1'b0} - CN_W'(1);
            else
               cn_d = {se_neg[VAL_W-1:0], 1'b0};
         end
         3'd2, 3'd3: begin
            if (me_bad)
               err_d = 1'b1;
            else if (bus.in_mode == 3'd2)
               cn_d = CN_W'(ME_INTRA[cbp]);
            else
               cn_d = CN_W'(ME_INTER[cbp]);
         end
         3'd4: begin
            if (!bus.in_te_max1)
               cn_d = {1'b0, bus.in_val};
            else if (|bus.in_val[VAL_W-1:1])
               err_d = 1'b1;
            else begin
               // cMax==1: single inverted bit instead of an Exp-Golomb code
               te1_d   = 1'b1;
               tebit_d = ~bus.in_val[0];
            end
         end
         default: err_d = 1'b1;
      endcase
   end

   // stage 2: codeword = codeNum+1 sent in 2M+1 bits, M = msb index of it
   assign cn1 = s1_cn + CN_W'(1);

   always_comb begin
      msb = '0;
      for (int i = 0; i < CN_W; i++)
         if (cn1[i]) msb = 6'(i);
   end

   always_comb begin
      code_d = '0;
      len_d  = '0;
      if (s1_err) begin
         code_d = '0;
      end else if (s1_te1) begin
         code_d[0] = s1_tebit;
         len_d     = 6'd1;
      end else begin
         code_d[CN_W-1:0] = cn1;
         len_d            = {msb[4:0], 1'b0} + 6'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_cn    <= '0;
         s1_err   <= 1'b0;
         s1_te1   <= 1'b0;
         s1_tebit <= 1'b0;
         s2_valid <= 1'b0;
         s2_code  <= '0;
         s2_len   <= '0;
         s2_err   <= 1'b0;
      end else begin
         if (acc) begin
            s1_valid <= 1'b1;
            s1_cn    <= cn_d;
            s1_err   <= err_d;
            s1_te1   <= te1_d;
            s1_tebit <= tebit_d;
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end
         // output register refills in the same cycle it drains
         if (s2_load) begin
            s2_valid <= 1'b1;
            s2_code  <= code_d;
            s2_len   <= len_d;
            s2_err   <= s1_err;
         end else if (bus.out_ready) begin
            s2_valid <= 1'b0;
         end
      end
   end

`ifdef EG_BITCNT_EN
   logic [16:0] cnt_sum;
   assign cnt_sum = {1'b0, bit_cnt} + 17'(s2_len);

   always_ff @(posedge clk) begin
      if (rst)
         bit_cnt <= '0;
      else if (mb_start)
         bit_cnt <= out_hs ? 16'(s2_len) : 16'd0;
      else if (out_hs)
         bit_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
   end
`else
   logic unused_mb_start;
   assign unused_mb_start = mb_start ^ out_hs;
   assign bit_cnt = '0;
`endif
endmodule

// File: tb/tb_seq_exp_golomb_enc.sv
// Bench for seq_exp_golomb_enc: directed vector table, multi-cycle corner
// sequences, and randomized streams checked against an arithmetic model.
module tb_seq_exp_golomb_enc;
   localparam int VW = 16;
   localparam int CW = 2*VW+1;
`ifdef EG_BITCNT_EN
   localparam bit BC = 1'b1;
`else
   localparam bit BC = 1'b0;
`endif

   typedef struct {
      logic [2:0]    mode;
      logic [VW-1:0] val;
      logic          te1;
   } elem_t;

   typedef struct {
      logic [CW-1:0] code;
      logic [5:0]    len;
      logic          err;
   } exp_t;

   typedef struct {
      elem_t e;
      exp_t  x;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mb_start = 1'b0;
   logic [15:0] bit_cnt;
   int          n_tests = 0;
   int          n_fail = 0;

   // me mapping table indexed by codeNum (ChromaArrayType 1/2)
   int me_intra[48] = '{47,31,15,0,23,27,29,30,7,11,13,14,39,43,45,46,
                        16,3,5,10,12,19,21,26,28,35,37,42,44,1,2,4,
                        8,17,18,20,24,6,9,22,25,32,33,34,36,40,38,41};
   int me_inter[48] = '{0,16,1,2,4,8,32,3,5,10,12,15,47,7,11,13,
                        14,6,9,31,35,37,42,44,33,34,36,40,39,43,45,46,
                        17,18,20,24,19,21,26,28,23,27,29,30,22,25,38,41};

   seq_exp_golomb_enc_if #(.VAL_W(VW), .CODE_W(CW)) bus();

   seq_exp_golomb_enc #(.VAL_W(VW), .CODE_W(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .mb_start (mb_start),
      .bit_cnt  (bit_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input elem_t e);
      exp_t   r;
      longint cn, sv;
      int     m;
      r.code = '0;
      r.len  = '0;
      r.err  = 1'b0;
      cn = 0;
      case (e.mode)
         3'd0: cn = longint'(e.val);
         3'd1: begin
            sv = longint'(e.val);
            if (e.val[VW-1]) sv = sv - (longint'(1) << VW);
            cn = (sv > 0) ? 2*sv - 1 : -2*sv;
         end
         3'd2, 3'd3: begin
            if (e.val > 47) begin
               r.err = 1'b1;
               return r;
            end
            for (int i = 0; i < 48; i++)
               if (((e.mode == 3'd2) ? me_intra[i] : me_inter[i]) == int'(e.val)) cn = i;
         end
         3'd4: begin
            if (e.te1) begin
               if (e.val > 1) r.err = 1'b1;
               else begin
                  r.code = (e.val == 0) ? CW'(1) : CW'(0);
                  r.len  = 6'd1;
               end
               return r;
            end
            cn = longint'(e.val);
         end
         default: begin
            r.err = 1'b1;
            return r;
         end
      endcase
      r.code = CW'(cn + 1);
      m = 0;
      while (((cn + 1) >> (m + 1)) != 0) m++;
      r.len = 6'(2*m + 1);
      return r;
   endfunction

   function automatic elem_t rand_elem();
      elem_t e;
      e.mode = 3'($urandom_range(0, 7));
      e.te1  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
         0, 1:    e.val = 16'($urandom);
         2:       e.val = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'hFFFF;
         3:       e.val = 16'($urandom_range(0, 2));
         default: e.val = 16'($urandom_range(0, 63));
      endcase
      return e;
   endfunction

   task automatic drive(input logic [2:0] mode, input logic [VW-1:0] val, input logic te1);
      bus.in_valid   = 1'b1;
      bus.in_mode    = mode;
      bus.in_val     = val;
      bus.in_te_max1 = te1;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Streams n elements; stall window [st_at, st_at+st_len) forces out_ready low.
   task automatic run_stream(input int n, input bit rnd, input int st_at, input int st_len);
      elem_t         el[$];
      exp_t          eq[$];
      exp_t          ex;
      int            sent = 0, got = 0, cyc = 0;
      bit            prev_stall = 1'b0;
      logic [CW-1:0] pc = '0;
      logic [5:0]    pl = '0;
      logic          pe = 1'b0;
      longint        exp_cnt = 0;
      bit            rdy_exp;
      for (int i = 0; i < n; i++) begin
         if (rnd) el.push_back(rand_elem());
         else     el.push_back('{3'd0, 16'(i*37), 1'b0});
      end
      while (got < n && cyc < 4000) begin
         @(negedge clk);
         if (sent < n && (!rnd || $urandom_range(0, 3) != 0))
            drive(el[sent].mode, el[sent].val, el[sent].te1);
         else
            bus.in_valid = 1'b0;
         if (cyc >= st_at && cyc < st_at + st_len) bus.out_ready = 1'b0;
         else bus.out_ready = rnd ? ($urandom_range(0, 99) < 70) : 1'b1;
         #1;
         if (prev_stall) begin
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_code", 64'(bus.out_code), 64'(pc));
            chk("hold_len", 64'(bus.out_len), 64'(pl));
            chk("hold_err", 64'(bus.out_err), 64'(pe));
         end
         rdy_exp = ((sent - got) < 2) || bus.out_ready;
         chk("in_ready", 64'(bus.in_ready), 64'(rdy_exp));
         chk("bit_cnt", 64'(bit_cnt), 64'(exp_cnt));
         if (bus.out_valid && bus.out_ready) begin
            if (eq.size() == 0) chk("spurious_out", 64'(bus.out_valid), 64'd0);
            else begin
               ex = eq.pop_front();
               chk("str_code", 64'(bus.out_code), 64'(ex.code));
               chk("str_len", 64'(bus.out_len), 64'(ex.len));
               chk("str_err", 64'(bus.out_err), 64'(ex.err));
               got++;
               if (BC) exp_cnt = (exp_cnt + ex.len > 65535) ? 65535 : exp_cnt + ex.len;
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            eq.push_back(model(el[sent]));
            sent++;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         pc = bus.out_code;
         pl = bus.out_len;
         pe = bus.out_err;
         cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("stream_count", 64'(got), 64'(n));
   endtask

   vec_t vt[$];

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_mode    = '0;
      bus.in_val     = '0;
      bus.in_te_max1 = 1'b0;
      bus.out_ready  = 1'b1;

      // expected codewords derived by hand from codeNum rules
      vt.push_back('{'{3'd0, 16'd0,     1'b0}, '{CW'(1),       6'd1,  1'b0}});
      vt.push_back('{'{3'd0, 16'd3,     1'b0}, '{CW'(4),       6'd5,  1'b0}});
      vt.push_back('{'{3'd0, 16'hFFFF,  1'b0}, '{CW'(65536),   6'd33, 1'b0}});
      vt.push_back('{'{3'd1, 16'hFFFE,  1'b0}, '{CW'(5),       6'd5,  1'b0}});
      vt.push_back('{'{3'd1, 16'd1,     1'b0}, '{CW'(2),       6'd3,  1'b0}});
      vt.push_back('{'{3'd1, 16'd0,     1'b0}, '{CW'(1),       6'd1,  1'b0}});
      vt.push_back('{'{3'd1, 16'h8000,  1'b0}, '{CW'(65537),   6'd33, 1'b0}});
      vt.push_back('{'{3'd1, 16'h7FFF,  1'b0}, '{CW'(65534),   6'd31, 1'b0}});
      vt.push_back('{'{3'd2, 16'd0,     1'b0}, '{CW'(4),       6'd5,  1'b0}});
      vt.push_back('{'{3'd2, 16'd47,    1'b0}, '{CW'(1),       6'd1,  1'b0}});
      vt.push_back('{'{3'd3, 16'd47,    1'b0}, '{CW'(13),      6'd7,  1'b0}});
      vt.push_back('{'{3'd3, 16'd0,     1'b0}, '{CW'(1),       6'd1,  1'b0}});
      vt.push_back('{'{3'd2, 16'd48,    1'b0}, '{CW'(0),       6'd0,  1'b1}});
      vt.push_back('{'{3'd3, 16'd64,    1'b0}, '{CW'(0),       6'd0,  1'b1}});
      vt.push_back('{'{3'd4, 16'd0,     1'b1}, '{CW'(1),       6'd1,  1'b0}});
      vt.push_back('{'{3'd4, 16'd1,     1'b1}, '{CW'(0),       6'd1,  1'b0}});
      vt.push_back('{'{3'd4, 16'd2,     1'b1}, '{CW'(0),       6'd0,  1'b1}});
      vt.push_back('{'{3'd4, 16'd5,     1'b0}, '{CW'(6),       6'd5,  1'b0}});
      vt.push_back('{'{3'd5, 16'd1,     1'b0}, '{CW'(0),       6'd0,  1'b1}});
      vt.push_back('{'{3'd7, 16'd0,     1'b0}, '{CW'(0),       6'd0,  1'b1}});

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_code", 64'(bus.out_code), 64'd0);
      chk("rst_out_len", 64'(bus.out_len), 64'd0);
      chk("rst_out_err", 64'(bus.out_err), 64'd0);
      chk("rst_bit_cnt", 64'(bit_cnt), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 64'(bus.in_ready), 64'd1);

      // back-to-back ue 0, 3: valid on cycles 2 and 3 after first accept
      @(negedge clk); drive(3'd0, 16'd0, 1'b0);
      @(negedge clk); drive(3'd0, 16'd3, 1'b0);
      #1 chk("b2b_c1_valid", 64'(bus.out_valid), 64'd0);
      @(negedge clk); bus.in_valid = 1'b0;
      #1 chk("b2b_c2_valid", 64'(bus.out_valid), 64'd1);
      chk("b2b_c2_code", 64'(bus.out_code), 64'd1);
      chk("b2b_c2_len", 64'(bus.out_len), 64'd1);
      @(negedge clk);
      #1 chk("b2b_c3_valid", 64'(bus.out_valid), 64'd1);
      chk("b2b_c3_code", 64'(bus.out_code), 64'd4);
      chk("b2b_c3_len", 64'(bus.out_len), 64'd5);
      chk("bitcnt_1", 64'(bit_cnt), BC ? 64'd1 : 64'd0);
      @(negedge clk);
      #1 chk("b2b_c4_valid", 64'(bus.out_valid), 64'd0);
      chk("bitcnt_6", 64'(bit_cnt), BC ? 64'd6 : 64'd0);

      // mb_start coinciding with the ue 1 output handshake
      @(negedge clk); drive(3'd0, 16'd1, 1'b0);
      @(negedge clk); bus.in_valid = 1'b0;
      @(negedge clk);
      #1 chk("mb_code", 64'(bus.out_code), 64'd2);
      mb_start = 1'b1;
      @(negedge clk); mb_start = 1'b0;
      #1 chk("bitcnt_mb", 64'(bit_cnt), BC ? 64'd3 : 64'd0);
      chk("mb_drained", 64'(bus.out_valid), 64'd0);

      // vector table, each with exact 2-cycle latency
      foreach (vt[k]) begin
         @(negedge clk);
         drive(vt[k].e.mode, vt[k].e.val, vt[k].e.te1);
         bus.out_ready = 1'b1;
         #1 chk($sformatf("vec%0d_ready", k), 64'(bus.in_ready), 64'd1);
         @(negedge clk); bus.in_valid = 1'b0;
         #1 chk($sformatf("vec%0d_lat1", k), 64'(bus.out_valid), 64'd0);
         @(negedge clk);
         #1 chk($sformatf("vec%0d_valid", k), 64'(bus.out_valid), 64'd1);
         chk($sformatf("vec%0d_code", k), 64'(bus.out_code), 64'(vt[k].x.code));
         chk($sformatf("vec%0d_len", k), 64'(bus.out_len), 64'(vt[k].x.len));
         chk($sformatf("vec%0d_err", k), 64'(bus.out_err), 64'(vt[k].x.err));
      end

      // 8 ue elements with a 3-cycle downstream stall mid-stream
      reset_dut();
      run_stream(8, 1'b0, 4, 3);

      // randomized stream against the model
      reset_dut();
      run_stream(300, 1'b1, 1000000, 0);

      // reset with both stages full and output stalled
      @(negedge clk);
      drive(3'd0, 16'd5, 1'b0);
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1 chk("full_ready", 64'(bus.in_ready), 64'd0);
      rst = 1'b1;
      #1 chk("rst_mid_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      #1 chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_mid_code", 64'(bus.out_code), 64'd0);
      chk("rst_mid_len", 64'(bus.out_len), 64'd0);
      chk("rst_mid_bitcnt", 64'(bit_cnt), 64'd0);
      bus.in_valid  = 1'b0;
      rst           = 1'b0;
      bus.out_ready = 1'b1;
      #1 chk("rst_mid_ready_after", 64'(bus.in_ready), 64'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1 chk("no_ghost_valid", 64'(bus.out_valid), 64'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/seq_exp_golomb_enc.md
SEQ_EXP_GOLOMB_ENC -- requirements
Module: seq_exp_golomb_enc

Interface
REQ-001 Parameter VAL_W, default 16, width of input value; legal range 8..16.
REQ-002 Parameter CODE_W, default 2*VAL_W+1, width of codeword output.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  syntax element present.
REQ-006 in_ready  output  1  element accepted when in_valid && in_ready.
REQ-007 in_mode  input  3  0=ue, 1=se, 2=me intra4x4, 3=me inter, 4=te; 5..7 illegal.
REQ-008 in_val  input  VAL_W  value: unsigned for ue/me/te, two's complement for se; me uses bits [5:0] as cbp.
REQ-009 in_te_max1  input  1  te only: range cMax==1.
REQ-010 out_valid  output  1  codeword present.
REQ-011 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-012 out_code  output  CODE_W  codeword, right-aligned, unused MSBs zero.
REQ-013 out_len  output  6  codeword bit length, 0..CODE_W.
REQ-014 out_err  output  1  qualified by out_valid; element illegal.
REQ-015 mb_start  input  1  clears bit counter (EG_BITCNT_EN only).
REQ-016 bit_cnt  output  16  accumulated emitted bits (EG_BITCNT_EN only).

Function
REQ-017 Stage 1 maps element to codeNum (VAL_W+1 bits); stage 2 builds codeword; both registered.
REQ-018 ue: codeNum = in_val.
REQ-019 se: in_val>0 -> 2*in_val-1; in_val<=0 -> -2*in_val; most-negative value yields codeNum 2^VAL_W without overflow.
REQ-020 me: codeNum per H.264 Table 9-4 (ChromaArrayType 1/2), intra4x4 or inter column per mode; cbp>47 or in_val[VAL_W-1:6]!=0 -> error.
REQ-021 te: in_te_max1=1 -> out_code = ~in_val[0], out_len=1, in_val>1 -> error; in_te_max1=0 -> as ue.
REQ-022 Codeword: M = floor(log2(codeNum+1)); out_len = 2M+1; out_code = codeNum+1.
REQ-023 Error (illegal mode, me/te range): out_err=1, out_len=0, out_code=0; element still occupies one output handshake.
REQ-024 Latency exactly 2 cycles from input handshake to out_valid when unstalled; throughput one element per cycle.
REQ-025 in_ready = !s1_valid || !s2_valid || out_ready; no combinational path in_valid -> out_valid.
REQ-026 While out_valid && !out_ready, out_code/out_len/out_err hold stable and no element is lost or duplicated.
REQ-027 Ordering preserved; stage 2 refills in the same cycle it drains.

Reset
REQ-028 rst=1 at clock edge: s1_valid=0, s2_valid=0, out_valid=0, out_code=0, out_len=0, out_err=0, bit_cnt=0.
REQ-029 Reset mid-stream discards all in-flight elements; in_ready=1 the cycle after rst deasserts.
REQ-030 in_ready=0 while rst is asserted.

Configuration
REQ-031 Macro EG_BITCNT_EN defined: bit_cnt adds out_len on each output handshake, saturates at 16'hFFFF; mb_start clears; mb_start with simultaneous handshake loads bit_cnt = out_len.
REQ-032 EG_BITCNT_EN undefined: counter logic absent, bit_cnt tied to 0, mb_start ignored.

Verification
REQ-033 ue in_val=0 then 3 -> out_code=1/len=1, then out_code=4/len=5, valid on cycles 2 and 3 after first accept.
REQ-034 se in_val=-2 -> codeNum 4, out_code=5, len=5; se in_val=+1 -> out_code=2, len=3.
REQ-035 me intra cbp=0 -> codeNum 3, out_code=4, len=5; me inter cbp=47 -> codeNum 12, out_code=13, len=7; me intra cbp=48 -> out_err=1, len=0.
REQ-036 te in_te_max1=1, in_val=0 -> out_code=1, len=1; in_val=2 -> out_err=1.
REQ-037 Stream 8 ue elements, out_ready low 3 cycles mid-stream -> outputs held stable, all 8 emitted in order, in_ready drops only when both stages full.
REQ-038 EG_BITCNT_EN: ue 0,3 then mb_start with ue 1 handshake -> bit_cnt 1, 6, then 3; rst mid-stream -> bit_cnt=0, out_valid=0.
